// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS32 core:
// opcodes, functs, FSM states, ALU ops and decode helpers.
package mips_pkg;

  localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] DEF_PORT_OUT  = 32'hFFFF_0000;
  localparam logic [31:0] DEF_PORT_IN   = 32'hFFFF_0004;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } aluOp_t;

  typedef enum logic [3:0] {
    K_ALUR, K_ALUI, K_LW, K_SW, K_BEQ,
    K_BNE, K_J, K_JAL, K_JR, K_ILL
  } kind_t;

  function automatic kind_t decodeKind(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    kind_t k;
    k = K_ILL;
    case (op)
      OP_RTYPE:
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR,
          FN_NOR, FN_SLT, FN_SLL, FN_SRL:
            k = K_ALUR;
          FN_JR:   k = K_JR;
          default: k = K_ILL;
        endcase
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:
        k = K_ALUI;
      OP_LW:   k = K_LW;
      OP_SW:   k = K_SW;
      OP_BEQ:  k = K_BEQ;
      OP_BNE:  k = K_BNE;
      OP_J:    k = K_J;
      OP_JAL:  k = K_JAL;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic aluOp_t decodeAlu(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    aluOp_t o;
    o = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  o = ALU_SUB;
        FN_AND:  o = ALU_AND;
        FN_OR:   o = ALU_OR;
        FN_NOR:  o = ALU_NOR;
        FN_SLT:  o = ALU_SLT;
        FN_SLL:  o = ALU_SLL;
        FN_SRL:  o = ALU_SRL;
        default: o = ALU_ADD;
      endcase
    end else begin
      case (op)
        OP_ANDI: o = ALU_AND;
        OP_ORI:  o = ALU_OR;
        OP_LUI:  o = ALU_LUI;
        default: o = ALU_ADD;
      endcase
    end
    return o;
  endfunction

  function automatic logic [31:0] aluCompute(
    input aluOp_t      op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  sh
  );
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOR: r = ~(a | b);
      ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: r = b << sh;
      ALU_SRL: r = b >> sh;
      ALU_LUI: r = {b[15:0], 16'h0000};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port with req/ready
// handshake; the core is master, the memory is slave.
interface mips_multicycle_core_if;
  logic        mem_req;
  logic        mem_instr;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_instr, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_instr, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM: state register, next-state logic and
// per-state strobes for memory, retire and regfile write.
module multicycle_control
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  kind_t  kind,
  input  logic   memReady,
  input  logic   portOutHit,
  input  logic   portInHit,
  output state_t state,
  output logic   memReq,
  output logic   memInstr,
  output logic   memWe,
  output logic   memAck,
  output logic   retire,
  output logic   regWrite
);

  state_t nextState;
  logic   reqRaw;
  logic   retRaw;
  logic   wrRaw;

  // state register, forced to FETCH by reset
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // next state and strobes for the current state
  always_comb begin
    nextState = state;
    reqRaw    = 1'b0;
    memInstr  = 1'b0;
    memWe     = 1'b0;
    retRaw    = 1'b0;
    wrRaw     = 1'b0;
    unique case (state)
      FETCH: begin
        reqRaw   = 1'b1;
        memInstr = 1'b1;
        if (memReady) nextState = DECODE;
      end
      DECODE: nextState = EXEC;
      EXEC: begin
        unique case (kind)
          K_ALUR, K_ALUI: nextState = WB;
          K_LW, K_SW:     nextState = MEM;
          default: begin
            nextState = FETCH;
            retRaw    = 1'b1;
            wrRaw     = (kind == K_JAL);
          end
        endcase
      end
      MEM: begin
        if (kind == K_SW && portOutHit) begin
          nextState = FETCH;
          retRaw    = 1'b1;
        end else if (kind == K_LW && portInHit) begin
          nextState = WB;
        end else begin
          reqRaw = 1'b1;
          memWe  = (kind == K_SW);
          if (memReady) begin
            nextState = memWe ? FETCH : WB;
            retRaw    = memWe;
          end
        end
      end
      WB: begin
        wrRaw     = 1'b1;
        retRaw    = 1'b1;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  assign memReq   = reqRaw & ~reset;
  assign memAck   = memReq & memReady;
  assign retire   = retRaw & ~reset;
  assign regWrite = wrRaw & ~reset;

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 core: datapath, regfile and ALU,
// sequenced by multicycle_control over one memory port.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE     = DEF_TEXT_BASE,
  parameter logic [31:0] DATA_BASE     = DEF_DATA_BASE,
  parameter logic [31:0] PORT_OUT_ADDR = DEF_PORT_OUT,
  parameter logic [31:0] PORT_IN_ADDR  = DEF_PORT_IN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  PortIn,
  mips_multicycle_core_if.master bus,
  output logic [31:0] ALUResultOut,
  output logic [31:0] PortOut,
  output logic        InstrRetired,
  output logic        IllegalOp
);

  logic [31:0] pc, ir, a, b, mdr, aluOut;
  logic [31:0] portOut;
  logic        illegal;
  logic [31:0] rf [32];

  state_t state;
  kind_t  kind;
  aluOp_t aluOp;
  logic   memAck, regWrite, portOutHit, portInHit;

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, shamt, wAddr;
  logic [31:0] immSe, immZe, bSel, aluRes;
  logic [31:0] wData, jTarget, addrRaw;

  assign opc     = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign fn      = ir[5:0];
  assign immSe   = {{16{ir[15]}}, ir[15:0]};
  assign immZe   = {16'h0000, ir[15:0]};
  assign jTarget = {pc[31:28], ir[25:0], 2'b00};

  assign kind  = decodeKind(opc, fn);
  assign aluOp = decodeAlu(opc, fn);

  assign portOutHit = (aluOut == PORT_OUT_ADDR);
  assign portInHit  = (aluOut == PORT_IN_ADDR);

  multicycle_control ctrl (
    .clk        (clk),
    .reset      (reset),
    .kind       (kind),
    .memReady   (bus.mem_ready),
    .portOutHit (portOutHit),
    .portInHit  (portInHit),
    .state      (state),
    .memReq     (bus.mem_req),
    .memInstr   (bus.mem_instr),
    .memWe      (bus.mem_we),
    .memAck     (memAck),
    .retire     (InstrRetired),
    .regWrite   (regWrite)
  );

  assign addrRaw = bus.mem_instr ? (pc - TEXT_BASE)
                                 : (aluOut - DATA_BASE);
  assign bus.mem_addr  = addrRaw & 32'hFFFF_FFFC;
  assign bus.mem_wdata = b;

  // second ALU operand: rt, sign- or zero-extended imm
  always_comb begin
    bSel = immZe;
    unique case (1'b1)
      kind == K_ALUR: bSel = b;
      opc == OP_ADDI,
      kind == K_LW,
      kind == K_SW:   bSel = immSe;
      default:        bSel = immZe;
    endcase
  end

  assign aluRes = aluCompute(aluOp, a, bSel, shamt);

  // writeback destination and data, jal links to $31
  always_comb begin
    wAddr = rt;
    wData = aluOut;
    if (kind == K_JAL) begin
      wAddr = 5'd31;
      wData = pc;
    end else if (kind == K_ALUR) begin
      wAddr = rd;
    end
    if (kind == K_LW) wData = mdr;
  end

  // register file, $0 never written so it reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regWrite && wAddr != 5'd0) begin
      rf[wAddr] <= wData;
    end
  end

  // datapath registers updated per FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= TEXT_BASE;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      aluOut  <= '0;
      portOut <= '0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (memAck) begin
            ir <= bus.mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a      <= rf[rs];
          b      <= rf[rt];
          aluOut <= pc + {immSe[29:0], 2'b00};
        end
        EXEC: begin
          unique case (kind)
            K_ALUR, K_ALUI,
            K_LW, K_SW: aluOut <= aluRes;
            K_BEQ: if (a == b) pc <= aluOut;
            K_BNE: if (a != b) pc <= aluOut;
            K_J, K_JAL: pc <= jTarget;
            K_JR: pc <= a;
            default: illegal <= 1'b1;
          endcase
        end
        MEM: begin
          if (kind == K_SW && portOutHit)
            portOut <= b;
          else if (kind == K_LW && portInHit)
            mdr <= {24'b0, PortIn};
          else if (memAck && kind == K_LW)
            mdr <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ALUResultOut = aluOut;
  assign PortOut      = portOut;
  assign IllegalOp    = illegal;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: runs a small
// program against a wait-state memory model.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  PortIn = 8'hA5;
  logic [31:0] ALUResultOut, PortOut;
  logic        InstrRetired, IllegalOp;

  mips_multicycle_core_if bus();

  mips_multicycle_core dut (
    .clk          (clk),
    .reset        (reset),
    .PortIn       (PortIn),
    .bus          (bus),
    .ALUResultOut (ALUResultOut),
    .PortOut      (PortOut),
    .InstrRetired (InstrRetired),
    .IllegalOp    (IllegalOp)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int iWait = 0;
  int dWait = 0;
  int waitCnt = 0;

  int compared = 0;
  int mismatched = 0;

  assign bus.mem_ready = bus.mem_req &&
    (waitCnt >= (bus.mem_instr ? iWait : dWait));
  assign bus.mem_rdata = bus.mem_instr ?
    imem[bus.mem_addr[7:2]] : dmem[bus.mem_addr[7:2]];

  // memory model: counts wait cycles, commits stores
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready) begin
      waitCnt <= 0;
      if (bus.mem_we)
        dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end else if (bus.mem_req) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
  end

  int          n, dReq;
  logic        fReq, fInstr, dStable, postIll;
  logic [31:0] fAddr, dAddr, dData, aluAtRet, postPort;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic runInstr();
    n = 0; dReq = 0; dStable = 1'b1;
    fReq = 1'b0; fInstr = 1'b0;
    fAddr = 'x; dAddr = 'x; dData = 'x;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        fReq   = bus.mem_req;
        fInstr = bus.mem_instr;
        fAddr  = bus.mem_addr;
      end
      if (bus.mem_req && !bus.mem_instr) begin
        if (dReq > 0 && (bus.mem_addr !== dAddr ||
                         bus.mem_wdata !== dData))
          dStable = 1'b0;
        dAddr = bus.mem_addr;
        dData = bus.mem_wdata;
        dReq++;
      end
    end while (InstrRetired !== 1'b1 && n < 40);
    aluAtRet = ALUResultOut;
    @(posedge clk); #1;
    postPort = PortOut;
    postIll  = IllegalOp;
  endtask

  task automatic step(input string tag,
                      input int expN,
                      input logic [31:0] expF);
    runInstr();
    chk({tag, ".cycles"}, n, expN);
    chk({tag, ".fetch"}, fAddr, expF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = 32'h2008_0005; // addi $8,$0,5
    imem[1]  = 32'h3C09_1001; // lui  $9,0x1001
    imem[2]  = 32'h3529_0008; // ori  $9,$9,8
    imem[3]  = 32'hAD28_0000; // sw   $8,0($9)
    imem[4]  = 32'h0C10_0014; // jal  0x00400050
    imem[5]  = 32'h0148_6022; // sub  $12,$10,$8
    imem[6]  = 32'hAD6C_0000; // sw   $12,0($11)
    imem[7]  = 32'h8D2F_0000; // lw   $15,0($9)
    imem[8]  = 32'h200E_0001; // addi $14,$0,1
    imem[9]  = 32'h21AD_0001; // addi $13,$13,1
    imem[10] = 32'h11AE_FFFE; // beq  $13,$14,-2
    imem[11] = 32'hAD6F_0000; // sw   $15,0($11)
    imem[12] = 32'h2010_FFFF; // addi $16,$0,-1
    imem[13] = 32'h0200_882A; // slt  $17,$16,$0
    imem[14] = 32'h0008_9027; // nor  $18,$0,$8
    imem[15] = 32'h0008_9900; // sll  $19,$8,4
    imem[16] = 32'hFC00_0000; // illegal opcode
    imem[17] = 32'hAD73_0000; // sw   $19,0($11)
    imem[18] = 32'h0810_0012; // j    self
    imem[20] = 32'h3C0B_FFFF; // lui  $11,0xFFFF
    imem[21] = 32'h8D6A_0004; // lw   $10,4($11)
    imem[22] = 32'hAD6A_0000; // sw   $10,0($11)
    imem[23] = 32'h03E0_0008; // jr   $ra

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req", bus.mem_req, 0);
    chk("rst.retire", InstrRetired, 0);
    chk("rst.illegal", IllegalOp, 0);
    chk("rst.portOut", PortOut, 0);
    chk("rst.alu", ALUResultOut, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    step("addi", 4, 32'h00);
    chk("addi.req", {fReq, fInstr}, 2'b11);
    chk("addi.alu", aluAtRet, 32'h5);
    step("lui", 4, 32'h04);
    chk("lui.alu", aluAtRet, 32'h1001_0000);
    step("ori", 4, 32'h08);
    chk("ori.alu", aluAtRet, 32'h1001_0008);

    dWait = 2;
    step("swWait", 6, 32'h0C);
    chk("swWait.reqCycles", dReq, 3);
    chk("swWait.addr", dAddr, 32'h8);
    chk("swWait.wdata", dData, 32'h5);
    chk("swWait.stable", dStable, 1);
    dWait = 0;

    step("jal", 3, 32'h10);
    step("luiIo", 4, 32'h50);
    chk("luiIo.alu", aluAtRet, 32'hFFFF_0000);
    step("lwIn", 5, 32'h54);
    chk("lwIn.noReq", dReq, 0);
    step("swOut", 4, 32'h58);
    chk("swOut.noReq", dReq, 0);
    chk("swOut.port", postPort, 32'h0000_00A5);
    step("jr", 3, 32'h5C);
    step("sub", 4, 32'h14);
    chk("sub.alu", aluAtRet, 32'hA0);
    step("swSub", 4, 32'h18);
    chk("swSub.port", postPort, 32'hA0);
    step("lwMem", 5, 32'h1C);
    chk("lwMem.reqCycles", dReq, 1);
    chk("lwMem.addr", dAddr, 32'h8);
    step("addi14", 4, 32'h20);
    step("addi13", 4, 32'h24);
    chk("addi13.alu", aluAtRet, 32'h1);
    step("beqTaken", 3, 32'h28);
    step("addi13b", 4, 32'h24);
    chk("addi13b.alu", aluAtRet, 32'h2);
    step("beqNot", 3, 32'h28);
    step("swLw", 4, 32'h2C);
    chk("swLw.port", postPort, 32'h5);
    step("addiNeg", 4, 32'h30);
    chk("addiNeg.alu", aluAtRet, 32'hFFFF_FFFF);
    step("slt", 4, 32'h34);
    chk("slt.alu", aluAtRet, 32'h1);
    step("nor", 4, 32'h38);
    chk("nor.alu", aluAtRet, 32'hFFFF_FFFA);
    chk("nor.illegal", postIll, 0);
    step("sll", 4, 32'h3C);
    chk("sll.alu", aluAtRet, 32'h50);
    step("illegal", 3, 32'h40);
    chk("illegal.flag", postIll, 1);
    step("swSll", 4, 32'h44);
    chk("swSll.port", postPort, 32'h50);
    chk("swSll.sticky", postIll, 1);
    step("jSelf", 3, 32'h48);
    step("jLoop", 3, 32'h48);

    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2.illegal", IllegalOp, 0);
    chk("rst2.port", PortOut, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step("addiR", 4, 32'h00);
    step("luiR", 4, 32'h04);
    step("oriR", 4, 32'h08);

    dWait = 1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req && !bus.mem_instr) && n < 20);
    chk("stall.cycles", n, 4);
    chk("stall.bus",
        {bus.mem_req, bus.mem_instr, bus.mem_we}, 3'b101);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.req", bus.mem_req, 0);
    chk("abort.port", PortOut, 0);
    dWait = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.fetch", {bus.mem_req, bus.mem_instr}, 2'b11);
    chk("abort.pc", bus.mem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
